serial_to_parallel_arbiter: RTL and testbench
=============================================

// Module: serial_to_parallel_arbiter
// PURPOSE
//  Shares one bit-serial deserializer between n_lanes serial requesters.
//  Requesters assert req; the block picks one round-robin and grants it.
//  It then shifts in exactly width valid bits from that lane.
//  Each word is emitted with its source lane id.
//  Sits between per-lane serial sources and a single downstream word consumer.
// PARAMETERS
//  width    8  bits per deserialized word (>=2)
//  n_lanes  4  number of serial requesters (>=2)
//  id_w     derived localparam = $clog2(n_lanes); not overridable
// PORTS
//  clk             in   1             single clock, all logic on posedge
//  rst             in   1             synchronous reset, active-high
//  req             in   n_lanes       lane i requests the deserializer
//  serial_valid    in   n_lanes       lane i bit qualifier
//  serial_data     in   n_lanes       lane i serial bit, LSB of word first
//  gnt             out  n_lanes       one-hot grant, registered
//  busy            out  1             a grant is active
//  parallel_valid  out  1             one-cycle pulse, word complete
//  parallel_data   out  width         assembled word
//  parallel_id     out  id_w          lane that produced parallel_data
//  abort           out  1             one-cycle pulse, grant lost before word complete
// BEHAVIOUR
//  Reset (sync): gnt=0, busy=0, parallel_valid=0, parallel_data=0, parallel_id=0, abort=0.
//  Reset also clears the bit counter and shift register, state=IDLE, rr pointer=n_lanes-1.
//  rst wins over every other event, including mid-word; the partial word is discarded.
//  FSM has two states: IDLE and BUSY.
//  IDLE: if any req at edge e, winner = first set req scanning from (ptr+1) mod n_lanes upward.
//   At e: gnt <= onehot(winner), busy <= 1, ptr <= winner, count <= 0, state <= BUSY.
//   No req at e: stay IDLE.
//  BUSY: only the granted lane's serial_valid/serial_data are sampled; other lanes are ignored.
//   Each edge with serial_valid[g]=1 shifts serial_data[g] in.
//   The first bit lands in parallel_data[0] and bit k lands in bit k.
//   Cycles with serial_valid[g]=0 hold count and shift state; gaps are unbounded.
//  Completion, at the edge sampling the width-th valid bit:
//   parallel_valid<=1 and parallel_data<=full word, including the current bit.
//   parallel_id<=g, gnt<=0, busy<=0, state<=IDLE.
//   Outputs are seen in the cycle after that edge.
//   parallel_data and parallel_id hold until the next completion; parallel_valid drops after 1 cycle.
//  Abort: req[g]=0 sampled in BUSY before completion.
//   At that edge: abort<=1 for 1 cycle, gnt<=0, busy<=0, partial word discarded, no parallel_valid.
//   If req[g]=0 and the completing bit arrive on the same edge, completion wins and abort stays 0.
//  Arbitration: the IDLE cycle after completion or abort is mandatory, so at most one word per width+1 cycles.
//   A new grant can issue at the first edge in IDLE.
//   ptr always advances to the last granted lane, whether it completed or aborted, so the order is fair.
//  Bit counter is $clog2(width+1) wide; it never wraps past width.
//  A downstream stall is not supported: the consumer must accept every parallel_valid.
// TESTING
//  1 Reset, req=4'b0010, lane1 sends 0xA5 LSB-first with no gaps -> gnt=0010 one cycle after req.
//    Then parallel_valid pulses 1 cycle after the 8th bit edge, data=0xA5, id=1, gnt=0.
//  2 req=4'b1111 held, each lane sends 0x10+i -> grant order 0,1,2,3,0.
//    Words 0x10,0x11,0x12,0x13 are emitted with ids 0..3.
//  3 Lane2 sends 0x3C with serial_valid low on alternate cycles -> single word 0x3C, id=2.
//    No early parallel_valid.
//  4 Lane0 granted sends 0xFF while lane3 toggles serial_valid and serial_data -> output 0xFF, id=0.
//    Lane3 bits are ignored.
//  5 Lane1 granted, req[1] drops after 3 bits, req[2]=1 -> abort pulse, no parallel_valid.
//    After 1 IDLE cycle gnt=0100.
//  6 rst asserted after 5 bits of lane0 -> all outputs 0 next cycle.
//    A fresh 0x5A on lane0 then yields 0x5A, id=0.

Source files
------------

// File: rtl/serial_to_parallel_arbiter_if.sv
// Bus between the serial requesters and the shared deserializer/arbiter.
// master: requester side (drives req and serial lanes).
// slave:  arbiter side (drives grant and the assembled-word outputs).
interface serial_to_parallel_arbiter_if #(
  parameter int unsigned width   = 8,
  parameter int unsigned n_lanes = 4
);
  localparam int unsigned id_w = $clog2(n_lanes);

  logic [n_lanes-1:0] req;
  logic [n_lanes-1:0] serial_valid;
  logic [n_lanes-1:0] serial_data;
  logic [n_lanes-1:0] gnt;
  logic               busy;
  logic               parallel_valid;
  logic [width-1:0]   parallel_data;
  logic [id_w-1:0]    parallel_id;
  logic               abort;

  modport master (
    output req, serial_valid, serial_data,
    input  gnt, busy, parallel_valid, parallel_data, parallel_id, abort
  );

  modport slave (
    input  req, serial_valid, serial_data,
    output gnt, busy, parallel_valid, parallel_data, parallel_id, abort
  );
endinterface

// File: rtl/serial_to_parallel_arbiter.sv
// Round-robin shares one bit-serial deserializer between n_lanes requesters.
// A granted lane shifts in exactly width valid bits (LSB first); the word is
// emitted with its lane id. Dropping req mid-word aborts the grant.
module serial_to_parallel_arbiter #(
  parameter int unsigned width   = 8,
  parameter int unsigned n_lanes = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  serial_to_parallel_arbiter_if.slave   io_bus
);

  localparam int unsigned id_w  = $clog2(n_lanes);
  localparam int unsigned cnt_w = $clog2(width + 1);
  localparam logic [cnt_w-1:0] LastBit = cnt_w'(width - 1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e              r_state;
  logic [id_w-1:0]     r_ptr;     // last granted lane; also the active lane while busy
  logic [cnt_w-1:0]    r_cnt;
  logic [width-1:0]    r_shift;
  logic [n_lanes-1:0]  r_gnt;
  logic                r_busy;
  logic                r_pvalid;
  logic [width-1:0]    r_pdata;
  logic [id_w-1:0]     r_pid;
  logic                r_abort;

  logic [id_w-1:0]     w_winner;
  logic [n_lanes-1:0]  w_onehot;
  logic                w_any_req;
  logic                w_bit_valid;
  logic                w_bit;
  logic                w_lane_req;
  logic                w_last;
  logic [width-1:0]    w_word;

  // First set request scanning upward from the lane after ptr, wrapping.
  function automatic logic [id_w-1:0] rr_pick(input logic [n_lanes-1:0] req,
                                              input logic [id_w-1:0]    ptr);
    logic [id_w-1:0] pick;
    logic            found;
    int unsigned     idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 1; i <= n_lanes; i++) begin
      idx = (32'(ptr) + i) % n_lanes;
      if (!found && req[id_w'(idx)]) begin
        pick  = id_w'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Arbitration pick and the granted lane's serial bit.
  always_comb begin
    w_any_req            = |io_bus.req;
    w_winner             = rr_pick(io_bus.req, r_ptr);
    w_onehot             = '0;
    w_onehot[w_winner]   = 1'b1;
    w_bit_valid          = io_bus.serial_valid[r_ptr];
    w_bit                = io_bus.serial_data[r_ptr];
    w_lane_req           = io_bus.req[r_ptr];
    w_last               = w_bit_valid && (r_cnt == LastBit);
    // New bit enters at the top; after width bits the first one sits at bit 0.
    w_word               = {w_bit, r_shift[width-1:1]};
  end

  // Two-state grant/deserialize FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_ptr    <= id_w'(n_lanes - 1);
      r_cnt    <= '0;
      r_shift  <= '0;
      r_gnt    <= '0;
      r_busy   <= 1'b0;
      r_pvalid <= 1'b0;
      r_pdata  <= '0;
      r_pid    <= '0;
      r_abort  <= 1'b0;
    end else begin
      r_pvalid <= 1'b0;
      r_abort  <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_gnt   <= w_onehot;
            r_busy  <= 1'b1;
            r_ptr   <= w_winner;
            r_cnt   <= '0;
            r_state <= StBusy;
          end
        end
        StBusy: begin
          // Completion takes priority over a simultaneous req drop.
          if (w_last) begin
            r_pvalid <= 1'b1;
            r_pdata  <= w_word;
            r_pid    <= r_ptr;
            r_gnt    <= '0;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_state  <= StIdle;
          end else if (!w_lane_req) begin
            r_abort <= 1'b1;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= StIdle;
          end else if (w_bit_valid) begin
            r_shift <= w_word;
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.gnt            = r_gnt;
  assign io_bus.busy           = r_busy;
  assign io_bus.parallel_valid = r_pvalid;
  assign io_bus.parallel_data  = r_pdata;
  assign io_bus.parallel_id    = r_pid;
  assign io_bus.abort          = r_abort;

endmodule

// File: tb/tb_serial_to_parallel_arbiter.sv
// Bench for serial_to_parallel_arbiter: directed scenarios plus random traffic,
// checked every cycle against a queue-based behavioural model.
module tb_serial_to_parallel_arbiter;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  serial_to_parallel_arbiter_if #(.width(W), .n_lanes(N)) bus ();

  serial_to_parallel_arbiter #(.width(W), .n_lanes(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, required 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           m_lane = -1;   // granted lane, -1 when nothing is granted
  int           m_ptr  = N - 1;
  int           m_c;
  int           m_word;
  bit           m_bits[$];
  bit           m_armed = 1'b0;
  int           m_words[$];    // (lane << 16) | word
  int           m_gnts[$];
  logic [N-1:0] e_gnt;
  logic         e_busy, e_pv, e_abort;
  logic [W-1:0] e_pd;
  logic [1:0]   e_pid;

  always @(posedge clk) begin
    if (rst) begin
      m_lane = -1; m_ptr = N - 1; m_bits.delete();
      e_gnt = '0; e_busy = 1'b0; e_pv = 1'b0; e_pd = '0; e_pid = '0; e_abort = 1'b0;
      m_armed = 1'b1;
    end else if (m_armed) begin
      e_pv = 1'b0;
      e_abort = 1'b0;
      if (m_lane < 0) begin
        for (int i = 1; i <= N; i++) begin
          m_c = (m_ptr + i) % N;
          if (m_lane < 0 && bus.req[m_c]) m_lane = m_c;
        end
        if (m_lane >= 0) begin
          m_ptr = m_lane;
          m_bits.delete();
          e_gnt = N'(1) << m_lane;
          e_busy = 1'b1;
          m_gnts.push_back(m_lane);
        end
      end else begin
        if (bus.serial_valid[m_lane]) m_bits.push_back(bus.serial_data[m_lane]);
        if (m_bits.size() == W) begin
          m_word = 0;
          for (int k = 0; k < W; k++) m_word += int'(m_bits[k]) * (1 << k);
          e_pv = 1'b1; e_pd = W'(m_word); e_pid = 2'(m_lane);
          e_gnt = '0; e_busy = 1'b0;
          m_words.push_back((m_lane << 16) | m_word);
          m_lane = -1;
        end else if (!bus.req[m_lane]) begin
          e_abort = 1'b1; e_gnt = '0; e_busy = 1'b0;
          m_lane = -1;
        end
      end
    end
  end

  // ---------------- compare process and DUT event logs ----------------
  int           dut_words[$];
  int           dut_gnts[$];
  logic [N-1:0] prev_gnt = '0;

  always @(negedge clk) begin
    if (m_armed) begin
      chk("gnt",   32'(bus.gnt), 32'(e_gnt));
      chk("busy",  32'(bus.busy), 32'(e_busy));
      chk("pvalid", 32'(bus.parallel_valid), 32'(e_pv));
      chk("pdata", 32'(bus.parallel_data), 32'(e_pd));
      chk("pid",   32'(bus.parallel_id), 32'(e_pid));
      chk("abort", 32'(bus.abort), 32'(e_abort));
    end
    if (bus.parallel_valid === 1'b1)
      dut_words.push_back((int'(bus.parallel_id) << 16) | int'(bus.parallel_data));
    if (bus.gnt != '0 && prev_gnt == '0) dut_gnts.push_back(int'(bus.gnt));
    prev_gnt = bus.gnt;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0; bus.serial_valid = '0; bus.serial_data = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_grant(output int lane, output int cycles);
    cycles = 0;
    lane = -1;
    while (bus.gnt == '0 && cycles < 50) begin
      tick();
      cycles++;
    end
    for (int j = 0; j < N; j++) if (bus.gnt[j]) lane = j;
    if (lane < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL grant_timeout at %0t: got no grant in %0d cycles, required one", $time, cycles);
    end
  endtask

  task automatic send_word(input int lane, input logic [W-1:0] word, input bit gaps,
                           input bit noise, input bit drop_last);
    if (lane < 0) return;
    for (int k = 0; k < W; k++) begin
      if (gaps && k > 0) begin
        bus.serial_valid[lane] = 1'b0;
        bus.serial_data[lane] = 1'($urandom);
        tick();
      end
      bus.serial_valid[lane] = 1'b1;
      bus.serial_data[lane] = word[k];
      if (noise) begin
        for (int j = 0; j < N; j++) begin
          if (j != lane) begin
            bus.serial_valid[j] = 1'($urandom);
            bus.serial_data[j] = 1'($urandom);
          end
        end
      end
      if (drop_last && k == W - 1) bus.req[lane] = 1'b0;
      tick();
    end
    bus.serial_valid = '0;
    bus.serial_data = '0;
  endtask

  task automatic chk_word(input string name, input int idx, input int exp);
    chk({name, "_dut"},   (idx < dut_words.size()) ? dut_words[idx] : -1, exp);
    chk({name, "_model"}, (idx < m_words.size()) ? m_words[idx] : -1, exp);
  endtask

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  int lane, cyc, base, gbase;
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    bus.req = '0; bus.serial_valid = '0; bus.serial_data = '0;

    // T1: reset state, single word 0xA5 from lane1.
    do_reset();
    chk("rst_gnt",  32'(bus.gnt), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_pd",   32'(bus.parallel_data), 32'h0);
    base = dut_words.size();
    bus.req = 4'b0010;
    wait_grant(lane, cyc);
    chk("t1_gnt_latency", 32'(cyc), 32'd1);
    chk("t1_gnt", 32'(bus.gnt), 32'b0010);
    send_word(lane, 8'hA5, 1'b0, 1'b0, 1'b1);
    chk("t1_pv",  32'(bus.parallel_valid), 32'h1);
    chk("t1_gnt_done", 32'(bus.gnt), 32'h0);
    tick();
    chk("t1_pv_drop", 32'(bus.parallel_valid), 32'h0);
    chk_word("t1_word", base, (1 << 16) | 'hA5);

    // T2: all lanes request, round-robin order 0,1,2,3,0 after reset.
    do_reset();
    base = dut_words.size();
    gbase = dut_gnts.size();
    bus.req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      wait_grant(lane, cyc);
      chk("t2_lane", 32'(lane), 32'(exp_order[r]));
      send_word(lane, W'(8'h10 + lane), 1'b0, 1'b0, 1'b0);
    end
    bus.req = '0;
    tick();
    for (int r = 0; r < 5; r++) begin
      chk("t2_gnt_dut", (gbase + r < dut_gnts.size()) ? dut_gnts[gbase + r] : -1,
          32'(1 << exp_order[r]));
      chk_word("t2_word", base + r, (exp_order[r] << 16) | ('h10 + exp_order[r]));
    end

    // T3: lane2 0x3C with gaps; req drops together with the last bit.
    base = dut_words.size();
    bus.req = 4'b0100;
    wait_grant(lane, cyc);
    send_word(lane, 8'h3C, 1'b1, 1'b0, 1'b1);
    chk("t3_pv", 32'(bus.parallel_valid), 32'h1);
    chk("t3_no_abort", 32'(bus.abort), 32'h0);
    tick();
    chk("t3_count", 32'(dut_words.size() - base), 32'd1);
    chk_word("t3_word", base, (2 << 16) | 'h3C);

    // T5: lane1 drops req after 3 bits while lane2 requests.
    base = dut_words.size();
    bus.req = 4'b0010;
    wait_grant(lane, cyc);
    chk("t5_lane", 32'(lane), 32'd1);
    for (int k = 0; k < 3; k++) begin
      bus.serial_valid[1] = 1'b1;
      bus.serial_data[1] = 1'(k);
      tick();
    end
    bus.serial_valid = '0;
    bus.req = 4'b0100;
    tick();
    chk("t5_abort", 32'(bus.abort), 32'h1);
    chk("t5_gnt0",  32'(bus.gnt), 32'h0);
    chk("t5_pv",    32'(bus.parallel_valid), 32'h0);
    tick();
    chk("t5_regrant", 32'(bus.gnt), 32'b0100);
    chk("t5_abort_drop", 32'(bus.abort), 32'h0);
    bus.req = '0;
    tick();
    tick();
    chk("t5_no_word", 32'(dut_words.size() - base), 32'd0);

    // T4: lane0 sends 0xFF while other lanes toggle.
    base = dut_words.size();
    bus.req = 4'b0001;
    wait_grant(lane, cyc);
    send_word(lane, 8'hFF, 1'b0, 1'b1, 1'b1);
    tick();
    chk_word("t4_word", base, 'hFF);

    // T6: reset mid-word, then a fresh 0x5A from lane0.
    bus.req = 4'b0001;
    wait_grant(lane, cyc);
    for (int k = 0; k < 5; k++) begin
      bus.serial_valid[0] = 1'b1;
      bus.serial_data[0] = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    chk("t6_gnt",   32'(bus.gnt), 32'h0);
    chk("t6_busy",  32'(bus.busy), 32'h0);
    chk("t6_pd",    32'(bus.parallel_data), 32'h0);
    chk("t6_pv",    32'(bus.parallel_valid), 32'h0);
    rst = 1'b0;
    bus.serial_valid = '0;
    base = dut_words.size();
    wait_grant(lane, cyc);
    send_word(lane, 8'h5A, 1'b0, 1'b0, 1'b1);
    tick();
    chk_word("t6_word", base, 'h5A);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(299) == 0);
      for (int j = 0; j < N; j++) if ($urandom_range(15) == 0) bus.req[j] = ~bus.req[j];
      bus.serial_valid = N'($urandom);
      bus.serial_data = N'($urandom);
      tick();
    end
    rst = 1'b0;
    bus.req = '0;
    bus.serial_valid = '0;
    tick(); tick(); tick();
    chk("word_count", 32'(dut_words.size()), 32'(m_words.size()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
